half_duplex_port: RTL and testbench
===================================

# half_duplex_port

Half-duplex endpoint for a shared tristate data bus: the active counterpart of the direction-controlled bidirectional buffer. It owns bus direction, serialises local transmit words onto the bus with a strobe, grants the bus to a peer on request, and captures the peer's words. A mandatory one-cycle turnaround separates every change of bus driver, and a burst limit keeps the peer from being starved. It sits between the core's valid/ready streams and the bidirectional pad.

## Interface
- WIDTH, 8, bus and data word width
- MAX_BURST, 4, max consecutive local words before the bus must be released (≥1)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- tx_data  input  WIDTH  local word to send
- tx_valid  input  1  tx_data valid
- tx_ready  output  1  word accepted on edge where tx_valid&tx_ready
- rx_data  output  WIDTH  last word captured from peer
- rx_valid  output  1  one-cycle pulse, rx_data new
- bus  inout  WIDTH  shared data bus; driven only when bus_oe=1, else high-Z
- bus_oe  output  1  registered drive enable
- bus_strb  output  1  registered; bus carries a valid local word this cycle
- peer_req  input  1  peer requests bus ownership; held for whole peer burst
- peer_gnt  output  1  registered; peer owns bus
- peer_strb  input  1  peer word valid on bus (honoured only while peer_gnt=1)

## Operation
- States: IDLE, TX, TURN, GRANT. Burst counter cnt (clog2(MAX_BURST)+1 bits).
- tx_ready (combinational) = !peer_req && ((IDLE) || (TX && cnt<MAX_BURST)). Always 0 in TURN/GRANT.
- IDLE: bus released. peer_req=1 → GRANT (peer wins ties with tx_valid). Else accept → TX, cnt=1.
- TX: bus_oe=1, bus=last accepted word, bus_strb=1. Accept → stay TX, cnt+1, new word next cycle. No accept (tx_valid=0, peer_req=1, or cnt=MAX_BURST) → TURN.
- TURN: bus_oe=0, bus_strb=0, cnt=0, exactly one cycle. Next: peer_req ? GRANT : IDLE.
- GRANT: peer_gnt=1, bus_oe=0. Each cycle with peer_strb=1: rx_data←bus, rx_valid=1 next cycle. peer_req=0 → TURN (peer_gnt=0); peer must release bus in the cycle it drops peer_req.
- peer_strb outside GRANT ignored; rx_data holds.
- No buffering: one word in flight on bus at most.

## Timing
- Reset values: state IDLE, bus_oe=0, bus_strb=0, bus high-Z, bus driver reg=0, peer_gnt=0, rx_valid=0, rx_data=0, cnt=0.
- Reset mid-TX/GRANT: next cycle bus released, peer_gnt=0; in-flight word dropped, no rx_valid.
- TX latency: accept at edge N → word on bus with bus_strb=1 for cycle N+1.
- Back-to-back: one word/cycle up to MAX_BURST; then ≥1 dead (TURN) cycle.
- Local→peer handover: last word cycle, one TURN cycle with bus high-Z, then peer_gnt=1.
- Peer→local: peer_req low → TURN → IDLE → earliest accept; first local word on bus 2 cycles after TURN.
- Grant from IDLE: peer_req high at edge → peer_gnt=1 next cycle.
- RX latency: peer_strb at edge N → rx_valid/rx_data valid cycle N+1.
- bus_oe and peer_gnt are never both 1; never both 1 on consecutive cycles.

## Test plan
- Reset, then tx_valid with 0xA5 → tx_ready=1; next cycle bus=0xA5, bus_oe=1, bus_strb=1; then TURN with bus=Z; IDLE.
- tx_valid held with 6 words (0x01..0x06), MAX_BURST=4 → 0x01..0x04 on consecutive cycles, one TURN cycle, 0x05, 0x06 follow.
- peer_req and tx_valid rise same cycle in IDLE → tx_ready=0, peer_gnt=1 next cycle; peer drives 0x3C with peer_strb → rx_data=0x3C, rx_valid one cycle.
- peer_req rises mid local burst → current word completes, one Z cycle, peer_gnt=1; check bus_oe/peer_gnt never overlap or abut.
- peer_strb pulsed while peer_gnt=0 with bus=0xFF → no rx_valid, rx_data unchanged.
- rst asserted during TX (bus=0x55) and during GRANT → next cycle bus_oe=0, bus_strb=0, peer_gnt=0, rx_valid=0, state IDLE.

Source files
------------

// File: rtl/half_duplex_port.sv
// ----------------------------------------------------------------------------
// half_duplex_port
//
// Half-duplex endpoint for a shared tristate data bus. The port owns the bus
// direction: it serialises local transmit words onto the bus with a strobe,
// hands the bus to a peer on request, and captures the words the peer sends
// while it holds the grant. Every change of bus driver is separated by one
// turnaround cycle in which nobody drives, and a local burst is capped at
// MAX_BURST words so a waiting peer is never starved.
//
// Parameters
//   WIDTH      bus and data word width
//   MAX_BURST  maximum consecutive local words before the bus is released
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   tx_data    local word to send
//   tx_valid   tx_data is valid
//   tx_ready   word accepted on an edge where tx_valid & tx_ready
//   rx_data    last word captured from the peer
//   rx_valid   one-cycle pulse, rx_data is new
//   bus        shared data bus, driven only while bus_oe = 1
//   bus_oe     registered drive enable for the bus
//   bus_strb   registered, bus carries a valid local word this cycle
//   peer_req   peer requests bus ownership, held for the whole peer burst
//   peer_gnt   registered, peer owns the bus
//   peer_strb  peer word valid on the bus (honoured only while peer_gnt = 1)
// ----------------------------------------------------------------------------
module half_duplex_port #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    inout  wire  [WIDTH-1:0] bus,
    output logic             bus_oe,
    output logic             bus_strb,
    input  logic             peer_req,
    output logic             peer_gnt,
    input  logic             peer_strb
);

    // One extra bit so the counter can hold MAX_BURST itself.
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        TX,
        TURN,
        GRANT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   bus_q;
    logic               accept;

    // A new local word can be taken when the bus is free or we are already
    // mid-burst with room left. A pending peer request blocks acceptance so
    // the peer wins any tie and an ongoing burst ends after the current word.
    assign tx_ready = !peer_req &&
                      ((state == IDLE) || ((state == TX) && (cnt < CNT_MAX)));

    assign accept = tx_valid && tx_ready;

    // The pad driver: the held word goes out only while we own the bus.
    assign bus = bus_oe ? bus_q : {WIDTH{1'bz}};

    // Bus ownership state machine. All outputs towards the bus and the peer
    // are registered here so that drive enable and grant change only on clock
    // edges; the TURN state guarantees the two are never active on
    // neighbouring cycles. rx_valid defaults low so it can only pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bus_q    <= '0;
            bus_oe   <= 1'b0;
            bus_strb <= 1'b0;
            peer_gnt <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (peer_req) begin
                        state    <= GRANT;
                        peer_gnt <= 1'b1;
                    end else if (accept) begin
                        state    <= TX;
                        cnt      <= CNT_ONE;
                        bus_q    <= tx_data;
                        bus_oe   <= 1'b1;
                        bus_strb <= 1'b1;
                    end
                end

                TX: begin
                    if (accept) begin
                        cnt   <= cnt + CNT_ONE;
                        bus_q <= tx_data;
                    end else begin
                        // Burst over (no data, peer waiting, or limit hit):
                        // release the bus for one dead cycle.
                        state    <= TURN;
                        cnt      <= '0;
                        bus_oe   <= 1'b0;
                        bus_strb <= 1'b0;
                    end
                end

                TURN: begin
                    if (peer_req) begin
                        state    <= GRANT;
                        peer_gnt <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end

                GRANT: begin
                    if (peer_strb) begin
                        rx_data  <= bus;
                        rx_valid <= 1'b1;
                    end
                    // The peer stops driving in the same cycle it drops its
                    // request, so the following TURN cycle is bus-idle.
                    if (!peer_req) begin
                        state    <= TURN;
                        peer_gnt <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    bus_oe   <= 1'b0;
                    bus_strb <= 1'b0;
                    peer_gnt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_half_duplex_port.sv
// ----------------------------------------------------------------------------
// tb_half_duplex_port
//
// Self-checking bench for half_duplex_port. A reference model tracks the
// expected port behaviour as a set of cycle rules (bus driven iff a word was
// accepted on the previous edge, grant iff the peer asked while we were not
// driving, a dead cycle after any driver release, burst length bound, receive
// capture one cycle after a granted strobe). Directed scenarios run first,
// followed by a randomised stretch.
// ----------------------------------------------------------------------------
module tb_half_duplex_port;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    wire  [WIDTH-1:0] bus;
    logic             bus_oe;
    logic             bus_strb;
    logic             peer_req;
    logic             peer_gnt;
    logic             peer_strb;

    // Peer side of the tristate bus.
    logic             peer_oe;
    logic [WIDTH-1:0] peer_bus;

    assign bus = peer_oe ? peer_bus : {WIDTH{1'bz}};

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    half_duplex_port #(
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .bus       (bus),
        .bus_oe    (bus_oe),
        .bus_strb  (bus_strb),
        .peer_req  (peer_req),
        .peer_gnt  (peer_gnt),
        .peer_strb (peer_strb)
    );

    int testCount = 0;
    int failCount = 0;

    // Reference model: expected outputs for the current cycle.
    logic             mValid = 1'b0;
    logic             mOe    = 1'b0;
    logic             mGnt   = 1'b0;
    logic             mTurn  = 1'b0;
    logic             mRxv   = 1'b0;
    logic             mAcc   = 1'b0;
    logic [WIDTH-1:0] mWord  = '0;
    logic [WIDTH-1:0] mRxd   = '0;
    int               mRun   = 0;

    // Observed enables from the previous cycle, for the no-abut rule.
    logic             prevOe  = 1'b0;
    logic             prevGnt = 1'b0;

    // Words seen on the bus with the strobe, in order.
    logic [WIDTH-1:0] seenQ[$];

    // Single comparison point: count it and report any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                     tag, actual, expected, $time);
        end
    endtask

    // Expected acceptance: no peer request, not granted, not in the dead
    // cycle after a release, and the burst has room left.
    function automatic logic expReady(input logic req);
        return !req && !mGnt && !mTurn && (mRun < MAX_BURST);
    endfunction

    // Drive one cycle of inputs, check outputs mid-cycle against the model,
    // advance the model across the next rising edge, and return #1 after it.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                                 input logic req, input logic ps,
                                 input logic poe, input logic [WIDTH-1:0] pb,
                                 input logic r);
        logic acc;
        logic nOe;
        logic nGnt;
        logic nRxv;
        tx_valid  = v;
        tx_data   = d;
        peer_req  = req;
        peer_strb = ps;
        peer_oe   = poe;
        peer_bus  = pb;
        rst       = r;
        @(negedge clk);
        if (mValid) begin
            checkOutput("tx_ready", {31'd0, tx_ready}, {31'd0, expReady(req)});
            checkOutput("bus_oe", {31'd0, bus_oe}, {31'd0, mOe});
            checkOutput("bus_strb", {31'd0, bus_strb}, {31'd0, mOe});
            checkOutput("peer_gnt", {31'd0, peer_gnt}, {31'd0, mGnt});
            checkOutput("rx_valid", {31'd0, rx_valid}, {31'd0, mRxv});
            checkOutput("rx_data", {24'd0, rx_data}, {24'd0, mRxd});
            if (mOe) begin
                checkOutput("bus_word", {24'd0, bus}, {24'd0, mWord});
            end
            checkOutput("oe_gnt_overlap", {31'd0, bus_oe & peer_gnt}, 32'd0);
            checkOutput("oe_gnt_abut",
                        {31'd0, (prevOe & peer_gnt) | (prevGnt & bus_oe)}, 32'd0);
        end
        if (bus_strb) seenQ.push_back(bus);
        prevOe  = bus_oe;
        prevGnt = peer_gnt;

        if (r) begin
            mValid = 1'b1;
            mOe    = 1'b0;
            mGnt   = 1'b0;
            mTurn  = 1'b0;
            mRxv   = 1'b0;
            mAcc   = 1'b0;
            mWord  = '0;
            mRxd   = '0;
            mRun   = 0;
        end else if (mValid) begin
            acc  = v && expReady(req);
            nOe  = acc;
            nGnt = req && !mOe;
            nRxv = mGnt && ps;
            mTurn = (mOe && !nOe) || (mGnt && !nGnt);
            mRun  = acc ? mRun + 1 : 0;
            if (acc) mWord = d;
            if (nRxv) mRxd = pb;
            mRxv = nRxv;
            mAcc = acc;
            mOe  = nOe;
            mGnt = nGnt;
        end
        @(posedge clk);
        #1;
    endtask

    // Quiet cycles with nothing requested.
    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, 0, 0, '0, 0);
    endtask

    // Directed scenarios followed by a randomised run.
    initial begin
        int         idx;
        int         guard;
        logic       rq;
        logic       v;
        logic       ps;
        logic       poe;
        logic       r;
        logic [7:0] dd;
        logic [7:0] pb;

        rst = 1'b1; tx_valid = 1'b0; tx_data = '0; peer_req = 1'b0;
        peer_strb = 1'b0; peer_oe = 1'b0; peer_bus = '0;
        @(posedge clk);
        #1;

        // Reset and its output values.
        applyStimulus(0, '0, 0, 0, 0, '0, 1);
        applyStimulus(0, '0, 0, 0, 0, '0, 1);
        checkOutput("reset_bus_oe", {31'd0, bus_oe}, 32'd0);
        checkOutput("reset_bus_strb", {31'd0, bus_strb}, 32'd0);
        checkOutput("reset_peer_gnt", {31'd0, peer_gnt}, 32'd0);
        checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("reset_rx_data", {24'd0, rx_data}, 32'd0);
        idleCycles(2);

        // Single word 0xA5: on the bus next cycle, then a dead cycle.
        applyStimulus(1, 8'hA5, 0, 0, 0, '0, 0);
        checkOutput("a5_bus", {24'd0, bus}, 32'hA5);
        checkOutput("a5_oe", {31'd0, bus_oe}, 32'd1);
        checkOutput("a5_strb", {31'd0, bus_strb}, 32'd1);
        applyStimulus(0, '0, 0, 0, 0, '0, 0);
        checkOutput("a5_turn_oe", {31'd0, bus_oe}, 32'd0);
        idleCycles(2);

        // Six words held valid: four back-to-back, TURN, IDLE, then two more.
        seenQ.delete();
        idx = 1;
        guard = 0;
        while (idx <= 6 && guard < 40) begin
            applyStimulus(1, 8'(idx), 0, 0, 0, '0, 0);
            if (mAcc) idx++;
            guard++;
        end
        idleCycles(3);
        checkOutput("burst_cycles", guard, 32'd8);
        checkOutput("burst_count", seenQ.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            checkOutput("burst_word",
                        (i < seenQ.size()) ? {24'd0, seenQ[i]} : 32'hFFFF,
                        i + 1);
        end

        // Peer request ties with tx_valid in IDLE: peer wins, sends 0x3C.
        applyStimulus(1, 8'h77, 1, 0, 0, '0, 0);
        checkOutput("tie_gnt", {31'd0, peer_gnt}, 32'd1);
        checkOutput("tie_no_oe", {31'd0, bus_oe}, 32'd0);
        applyStimulus(0, '0, 1, 1, 1, 8'h3C, 0);
        checkOutput("rx_3c_valid", {31'd0, rx_valid}, 32'd1);
        checkOutput("rx_3c_data", {24'd0, rx_data}, 32'h3C);
        applyStimulus(0, '0, 1, 0, 1, 8'h00, 0);
        checkOutput("rx_3c_pulse", {31'd0, rx_valid}, 32'd0);
        applyStimulus(0, '0, 0, 0, 0, '0, 0);
        idleCycles(2);

        // Peer request mid local burst: current word completes, one Z cycle.
        applyStimulus(1, 8'h11, 0, 0, 0, '0, 0);
        applyStimulus(1, 8'h12, 0, 0, 0, '0, 0);
        applyStimulus(1, 8'h13, 1, 0, 0, '0, 0);
        checkOutput("mid_turn_oe", {31'd0, bus_oe}, 32'd0);
        checkOutput("mid_turn_gnt", {31'd0, peer_gnt}, 32'd0);
        applyStimulus(1, 8'h14, 1, 0, 0, '0, 0);
        checkOutput("mid_gnt", {31'd0, peer_gnt}, 32'd1);
        applyStimulus(0, '0, 1, 1, 1, 8'h5A, 0);
        applyStimulus(0, '0, 0, 0, 0, '0, 0);
        idleCycles(2);

        // Peer strobe without grant, bus driven 0xFF: ignored.
        applyStimulus(0, '0, 0, 1, 1, 8'hFF, 0);
        checkOutput("nogrant_rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("nogrant_rx_data", {24'd0, rx_data}, 32'h5A);
        idleCycles(1);

        // Reset during TX with 0x55 on the bus.
        applyStimulus(1, 8'h55, 0, 0, 0, '0, 0);
        checkOutput("rst_tx_bus", {24'd0, bus}, 32'h55);
        applyStimulus(1, 8'h66, 0, 0, 0, '0, 1);
        checkOutput("rst_tx_oe", {31'd0, bus_oe}, 32'd0);
        checkOutput("rst_tx_strb", {31'd0, bus_strb}, 32'd0);
        checkOutput("rst_tx_gnt", {31'd0, peer_gnt}, 32'd0);
        checkOutput("rst_tx_idle", {31'd0, tx_ready}, 32'd1);

        // Reset during GRANT with a strobe in flight.
        applyStimulus(0, '0, 1, 0, 0, '0, 0);
        checkOutput("rst_g_pre", {31'd0, peer_gnt}, 32'd1);
        applyStimulus(0, '0, 1, 1, 1, 8'h99, 1);
        checkOutput("rst_g_gnt", {31'd0, peer_gnt}, 32'd0);
        checkOutput("rst_g_rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("rst_g_rx_data", {24'd0, rx_data}, 32'd0);
        checkOutput("rst_g_oe", {31'd0, bus_oe}, 32'd0);
        applyStimulus(0, '0, 0, 0, 0, '0, 0);
        idleCycles(2);

        // Randomised traffic. The peer holds its request for a whole burst,
        // drives the bus whenever it owns it, never strobes in the cycle it
        // lets go, and only drives junk when the local side is not driving.
        rq = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            v  = ($urandom_range(0, 3) != 0);
            dd = 8'($urandom);
            pb = 8'($urandom);
            if (rq) rq = ($urandom_range(0, 5) != 0);
            else    rq = ($urandom_range(0, 7) == 0);
            if (mGnt) begin
                poe = rq;
                ps  = rq && ($urandom_range(0, 1) == 1);
            end else begin
                poe = !mOe && ($urandom_range(0, 1) == 1);
                ps  = ($urandom_range(0, 2) == 0);
            end
            r = ($urandom_range(0, 199) == 0);
            applyStimulus(v, dd, rq, ps, poe, pb, r);
        end
        idleCycles(2);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
